// File: rtl/gate_response_checker.sv
// Sequences the four 2-input vectors through an external gate block, waits SETTLE_CYCLES,
// and tallies mismatching response bits. Define GATE_CHK_ERRLOG_EN to add the first-failure log.
module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  input  logic [6:0] resp_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt
`ifdef GATE_CHK_ERRLOG_EN
  ,
  output logic       first_fail_vld,
  output logic [1:0] first_fail_vec,
  output logic [6:0] first_fail_mask
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  // Bit order: AND, OR, NOT a, NAND, NOR, XOR, XNOR.
  function automatic logic [6:0] expected_resp(input logic a, input logic b);
    expected_resp = {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  function automatic logic [4:0] popcount7(input logic [6:0] v);
    logic [4:0] sum;
    sum = 5'd0;
    for (int i = 0; i < 7; i++) begin
      sum = sum + {4'd0, v[i]};
    end
    popcount7 = sum;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [4:0] err_q, err_d;
  logic [6:0] mismatch_s;
  logic [4:0] err_sum_s;
  logic [1:0] idx_inc_s;
`ifdef GATE_CHK_ERRLOG_EN
  logic       log_vld_q, log_vld_d;
  logic [1:0] log_vec_q, log_vec_d;
  logic [6:0] log_mask_q, log_mask_d;
`endif

  assign mismatch_s = resp_i ^ expected_resp(a_q, b_q);
  assign err_sum_s  = err_q + popcount7(mismatch_s);
  assign idx_inc_s  = idx_q + 2'd1;

  // Next-state and next-output computation for the check sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
`ifdef GATE_CHK_ERRLOG_EN
    log_vld_d  = log_vld_q;
    log_vec_d  = log_vec_q;
    log_mask_d = log_mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          err_d   = 5'd0;
          pass_d  = 1'b0;
`ifdef GATE_CHK_ERRLOG_EN
          log_vld_d  = 1'b0;
          log_vec_d  = 2'd0;
          log_mask_d = 7'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        err_d = err_sum_s;
`ifdef GATE_CHK_ERRLOG_EN
        if (!log_vld_q && (mismatch_s != 7'd0)) begin
          log_vld_d  = 1'b1;
          log_vec_d  = idx_q;
          log_mask_d = mismatch_s;
        end else begin
          log_vld_d  = log_vld_q;
        end
`endif
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_sum_s == 5'd0);
        end else begin
          // Vector outputs change on the same edge that re-enters DRIVE.
          state_d = ST_DRIVE;
          idx_d   = idx_inc_s;
          a_d     = idx_inc_s[1];
          b_d     = idx_inc_s[0];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 5'd0;
`ifdef GATE_CHK_ERRLOG_EN
      log_vld_q  <= 1'b0;
      log_vec_q  <= 2'd0;
      log_mask_q <= 7'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
`ifdef GATE_CHK_ERRLOG_EN
      log_vld_q  <= log_vld_d;
      log_vec_q  <= log_vec_d;
      log_mask_q <= log_mask_d;
`endif
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
`ifdef GATE_CHK_ERRLOG_EN
  assign first_fail_vld  = log_vld_q;
  assign first_fail_vec  = log_vec_q;
  assign first_fail_mask = log_mask_q;
`endif

endmodule
